// File: rtl/term_enumerator_pkg.sv
// Shared types and constants for the canonical-term enumerator.
package term_enumerator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic MODE_SOP = 1'b0;
    localparam logic MODE_POS = 1'b1;

endpackage

// File: rtl/term_enumerator.sv
// Walks an N-input truth table and streams minterm (SOP) or maxterm (POS)
// indices over valid/ready, then reports the term count with a done pulse.
module term_enumerator
    import term_enumerator_pkg::*;
#(
    parameter int N_IN = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  mode,
    input  logic [2**N_IN-1:0]    tt,
    output logic                  term_valid,
    input  logic                  term_ready,
    output logic [N_IN-1:0]       term_idx,
    output logic [N_IN:0]         term_count,
    output logic                  busy,
    output logic                  done
);

    localparam int TT_W  = 2**N_IN;
    localparam int CNT_W = N_IN + 1;
    localparam logic [N_IN-1:0] LAST_IDX = '1;

    state_t            state, stateNext;
    logic [TT_W-1:0]   ttQ, ttQNext;
    logic              modeQ, modeQNext;
    logic [N_IN-1:0]   idx, idxNext;
    logic              validNext;
    logic [N_IN-1:0]   termIdxNext;
    logic [CNT_W-1:0]  countNext;
    logic              busyNext;
    logic              doneNext;
    logic              sel;

    // A term is an index whose Y matches the mode: Y=1 for SOP, Y=0 for POS.
    assign sel = ttQ[idx] ^ modeQ;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ttQ        <= '0;
            modeQ      <= MODE_SOP;
            idx        <= '0;
            term_valid <= 1'b0;
            term_idx   <= '0;
            term_count <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= stateNext;
            ttQ        <= ttQNext;
            modeQ      <= modeQNext;
            idx        <= idxNext;
            term_valid <= validNext;
            term_idx   <= termIdxNext;
            term_count <= countNext;
            busy       <= busyNext;
            done       <= doneNext;
        end
    end

    always_comb begin
        stateNext   = state;
        ttQNext     = ttQ;
        modeQNext   = modeQ;
        idxNext     = idx;
        validNext   = term_valid;
        termIdxNext = term_idx;
        countNext   = term_count;
        doneNext    = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    ttQNext   = tt;
                    modeQNext = mode;
                    idxNext   = '0;
                    countNext = '0;
                    stateNext = SCAN;
                end
            end
            SCAN: begin
                if (sel) begin
                    validNext   = 1'b1;
                    termIdxNext = idx;
                    stateNext   = EMIT;
                end else if (idx == LAST_IDX) begin
                    stateNext = DONE;
                    doneNext  = 1'b1;
                end else begin
                    idxNext = idx + 1'b1;
                end
            end
            EMIT: begin
                // Terminal check precedes the increment so idx never wraps.
                if (term_ready) begin
                    validNext = 1'b0;
                    countNext = term_count + 1'b1;
                    if (idx == LAST_IDX) begin
                        stateNext = DONE;
                        doneNext  = 1'b1;
                    end else begin
                        idxNext   = idx + 1'b1;
                        stateNext = SCAN;
                    end
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        busyNext = (stateNext != IDLE);
    end

endmodule

// File: doc/term_enumerator.md
Name: term_enumerator

Overview:
- Parametrised sequential successor to the lab's fixed 3-input SOP/POS function blocks.
- Accepts an N-input truth table on a start strobe and snapshots it.
- Walks all 2^N input combinations, one index per cycle.
- Streams out the canonical minterm indices (SOP mode) or maxterm indices (POS mode) over a valid/ready handshake, then reports the term count and a done pulse.
- Feeds the lab's display/checker path, so every canonical form is generated by one block instead of hand-written per exercise.

Parameters:
- N_IN, 3, number of function inputs; legal range 2..6.
- TT_W, 2**N_IN, localparam; truth-table width.
- CNT_W, N_IN+1, localparam; term counter width, so the count can hold 2^N.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin an enumeration; sampled only in IDLE.
- mode  in  1  0 = SOP (emit indices with Y=1), 1 = POS (emit indices with Y=0); sampled with start.
- tt  in  TT_W  truth table. Bit i is Y for input combination i, first input (A) is the MSB of i. Sampled with start.
- term_valid  out  1  term_idx holds a term.
- term_ready  in  1  consumer accepts the term.
- term_idx  out  N_IN  minterm/maxterm index.
- term_count  out  CNT_W  terms emitted in the current or last run.
- busy  out  1  high in SCAN, EMIT and DONE.
- done  out  1  one-cycle pulse at end of run.

Behaviour:
- Reset (async, any state): state=IDLE; term_valid=0, term_idx=0, term_count=0, busy=0, done=0; internal idx and snapshots cleared. Reset mid-run abandons the run and emits nothing further.
- All outputs are registered.
- IDLE:
  - start=1 at edge k: latch tt_q=tt, mode_q=mode; set idx=0, term_count=0, busy=1; state=SCAN at k+1.
  - start=0: state unchanged.
- SCAN: sel = tt_q[idx] XOR mode_q.
  - sel=1: register term_valid=1, term_idx=idx; go to EMIT.
  - sel=0 and idx==TT_W-1: go to DONE.
  - sel=0 otherwise: idx++ and stay in SCAN. Each skipped index costs one cycle.
- EMIT:
  - term_valid and term_idx stay stable until term_ready=1; no drop, no change under backpressure.
  - Handshake (valid & ready) at an edge: term_count++, term_valid=0.
  - After the handshake: if idx==TT_W-1 go to DONE, else idx++ and go to SCAN.
  - term_ready is ignored while term_valid=0.
- DONE: done=1 for exactly one cycle; busy drops with done; next state IDLE. term_count holds until the next accepted start.
- Minimum latency, no backpressure: start edge k to done high = TT_W+1+(number of terms) cycles.
- start outside IDLE, including the DONE cycle, is ignored. tt and mode changes during a run have no effect.
- Empty set (SOP with tt=0, or POS with tt all ones): no term_valid; done after TT_W+1 cycles; term_count=0.
- Full set: TT_W terms; term_count=TT_W with no overflow, since CNT_W = N_IN+1.
- idx never wraps; the terminal check happens before any increment.

Decomposition:
- Shared package: state enum {IDLE, SCAN, EMIT, DONE}; constants MODE_SOP=1'b0 and MODE_POS=1'b1.
- Single module; no sub-module is needed. The FSM, idx counter and term counter are small enough to live together.

Test Plan:
- N_IN=3, tt=8'b1011_0000 (Y=AB'+AC), mode=SOP, term_ready=1 -> term_idx 4,5,7 in order; term_count=3; one done pulse.
- Same tt, mode=POS -> term_idx 0,1,2,3,6; term_count=5.
- Same tt, SOP, term_ready held 0 for 5 cycles after the first valid -> term_idx=4 stable with valid high throughout; sequence unchanged; term_count=3.
- tt=8'h00 in SOP and tt=8'hFF in SOP -> no valid with count=0; then 8 terms (0..7) with count=8.
- Reset asserted in EMIT at index 5 (mid-cycle, async) -> all outputs 0 immediately; a subsequent start with tt=8'h01 in SOP -> single term 0, count=1.
- N_IN=4, tt=16'h8001, POS, start pulsed again while busy -> second start ignored; indices 1..14 emitted; count=14.
